// File: rtl/tri_setup_pkg.sv
// -----------------------------------------------------------------------------
// tri_setup_pkg
// Shared definitions for the triangle setup stage: FSM state encoding, the
// edge vertex-index table and the derived coefficient/area widths.
// No ports (package).
// -----------------------------------------------------------------------------
package tri_setup_pkg;

  localparam int TRI_WIDTH = 13;

  function automatic int c_width(input int w);
    return 2 * w;
  endfunction

  // Two guard bits so the sum of three full-width C terms cannot overflow.
  function automatic int area_width(input int w);
    return 2 * w + 2;
  endfunction

  localparam int TRI_C_WIDTH    = c_width(TRI_WIDTH);
  localparam int TRI_AREA_WIDTH = area_width(TRI_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELTA = 2'd1,
    MUL   = 2'd2,
    EMIT  = 2'd3
  } state_e;

  // Edge k runs from vertex EDGE_I[k] to vertex EDGE_J[k].
  localparam int EDGE_I [3] = '{0, 1, 2};
  localparam int EDGE_J [3] = '{1, 2, 0};

endpackage

// File: rtl/signed_sub.sv
// -----------------------------------------------------------------------------
// signed_sub
// Edge delta in the pipeline's sign-preserving, one-bit-dropped convention:
// the WIDTH+1-bit difference p - q keeps its sign bit and its low WIDTH-1 bits,
// so the result stays WIDTH bits wide.
// Ports:
//   p_i  in   WIDTH  minuend (signed)
//   q_i  in   WIDTH  subtrahend (signed)
//   d_o  out  WIDTH  delta (signed)
// -----------------------------------------------------------------------------
module signed_sub
  import tri_setup_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH
) (
  input  logic signed [WIDTH-1:0] p_i,
  input  logic signed [WIDTH-1:0] q_i,
  output logic signed [WIDTH-1:0] d_o
);

  logic [WIDTH:0] diff;

  assign diff = {p_i[WIDTH-1], p_i} - {q_i[WIDTH-1], q_i};
  // Bit WIDTH-1 is the one dropped.
  assign d_o  = {diff[WIDTH], diff[WIDTH-2:0]};

endmodule

// File: rtl/tri_setup.sv
// -----------------------------------------------------------------------------
// tri_setup
// Triangle setup for the raster front end. Takes one triangle over a
// valid/ready handshake, computes per-edge A/B (deltas) and C (cross terms)
// coefficients plus the doubled signed area (CCW positive), and presents them
// on a registered valid/ready output.
//
// Build option: TRI_SETUP_CULL_EN
//   defined   -> triangles with area <= 0 are dropped; cull_drop pulses once.
//   undefined -> every triangle is emitted; cull_drop is tied low.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           input handshake (ready only in IDLE)
//   x0,y0,x1,y1,x2,y2  [W]      signed vertex coordinates
//   out_valid/out_ready         output handshake
//   a0,b0,a1,b1,a2,b2  [W]      signed edge A/B coefficients
//   c0,c1,c2           [2W]     signed edge C coefficients
//   area               [2W+2]   signed doubled area
//   cull_drop                   one-cycle pulse per culled triangle
//
// state | meaning
// IDLE  | ready for a triangle; coordinates latched on accept
// DELTA | register the six edge deltas, clear the area accumulator
// MUL   | k = 0..2: compute C_k with two shared multipliers, accumulate area
// EMIT  | out_valid high, outputs held until out_ready
// -----------------------------------------------------------------------------
module tri_setup
  import tri_setup_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   x0,
  input  logic signed [WIDTH-1:0]   y0,
  input  logic signed [WIDTH-1:0]   x1,
  input  logic signed [WIDTH-1:0]   y1,
  input  logic signed [WIDTH-1:0]   x2,
  input  logic signed [WIDTH-1:0]   y2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   a0,
  output logic signed [WIDTH-1:0]   b0,
  output logic signed [WIDTH-1:0]   a1,
  output logic signed [WIDTH-1:0]   b1,
  output logic signed [WIDTH-1:0]   a2,
  output logic signed [WIDTH-1:0]   b2,
  output logic signed [2*WIDTH-1:0] c0,
  output logic signed [2*WIDTH-1:0] c1,
  output logic signed [2*WIDTH-1:0] c2,
  output logic signed [2*WIDTH+1:0] area,
  output logic                      cull_drop
);

  localparam int CW = c_width(WIDTH);
  localparam int AW = area_width(WIDTH);

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic signed [WIDTH-1:0] vx_q [3];
  logic signed [WIDTH-1:0] vx_d [3];
  logic signed [WIDTH-1:0] vy_q [3];
  logic signed [WIDTH-1:0] vy_d [3];
  logic signed [WIDTH-1:0] da_q [3];
  logic signed [WIDTH-1:0] da_d [3];
  logic signed [WIDTH-1:0] db_q [3];
  logic signed [WIDTH-1:0] db_d [3];
  logic signed [WIDTH-1:0] da_w [3];
  logic signed [WIDTH-1:0] db_w [3];
  logic signed [CW-1:0]    c_q [3];
  logic signed [CW-1:0]    c_d [3];
  logic signed [AW-1:0]    area_q, area_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0] xi, yi, xj, yj;
  logic [CW-1:0]           prod_ij, prod_ji;
  logic signed [CW-1:0]    c_w;

`ifdef TRI_SETUP_CULL_EN
  logic cull_q, cull_d;
`endif

  // A_k = delta(y_i, y_j), B_k = delta(x_j, x_i)
  for (genvar e = 0; e < 3; e++) begin : g_edge
    signed_sub #(.WIDTH(WIDTH)) u_sub_a (
      .p_i (vy_q[EDGE_I[e]]),
      .q_i (vy_q[EDGE_J[e]]),
      .d_o (da_w[e])
    );
    signed_sub #(.WIDTH(WIDTH)) u_sub_b (
      .p_i (vx_q[EDGE_J[e]]),
      .q_i (vx_q[EDGE_I[e]]),
      .d_o (db_w[e])
    );
  end

  // Operand select for the current edge.
  always_comb begin
    xi = '0;
    yi = '0;
    xj = '0;
    yj = '0;
    for (int e = 0; e < 3; e++) begin
      if (k_q == 2'(e)) begin
        xi = vx_q[EDGE_I[e]];
        yi = vy_q[EDGE_I[e]];
        xj = vx_q[EDGE_J[e]];
        yj = vy_q[EDGE_J[e]];
      end
    end
  end

  // Operands sign-extended to CW so the low CW bits are the exact signed product.
  assign prod_ij = {{WIDTH{xi[WIDTH-1]}}, xi} * {{WIDTH{yj[WIDTH-1]}}, yj};
  assign prod_ji = {{WIDTH{xj[WIDTH-1]}}, xj} * {{WIDTH{yi[WIDTH-1]}}, yi};
  assign c_w     = prod_ij - prod_ji;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    da_d        = da_q;
    db_d        = db_q;
    c_d         = c_q;
    area_d      = area_q;
    out_valid_d = out_valid_q;
`ifdef TRI_SETUP_CULL_EN
    cull_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vx_d    = '{x0, x1, x2};
          vy_d    = '{y0, y1, y2};
          state_d = DELTA;
        end
      end
      DELTA: begin
        da_d    = da_w;
        db_d    = db_w;
        area_d  = '0;
        k_d     = '0;
        state_d = MUL;
      end
      MUL: begin
        for (int e = 0; e < 3; e++) begin
          if (k_q == 2'(e)) c_d[e] = c_w;
        end
        area_d = area_q + {{2{c_w[CW-1]}}, c_w};
        k_d    = k_q + 2'd1;
        if (k_q == 2'd2) begin
          k_d = '0;
`ifdef TRI_SETUP_CULL_EN
          // Decision uses the final area including C_2, so no extra cycle.
          if (area_d[AW-1] || (area_d == '0)) begin
            state_d = IDLE;
            cull_d  = 1'b1;
          end else begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
          end
`else
          state_d     = EMIT;
          out_valid_d = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      vx_q        <= '{default: '0};
      vy_q        <= '{default: '0};
      da_q        <= '{default: '0};
      db_q        <= '{default: '0};
      c_q         <= '{default: '0};
      area_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      da_q        <= da_d;
      db_q        <= db_d;
      c_q         <= c_d;
      area_q      <= area_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef TRI_SETUP_CULL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) cull_q <= 1'b0;
    else        cull_q <= cull_d;
  end
  assign cull_drop = cull_q;
`else
  assign cull_drop = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign a0        = da_q[0];
  assign b0        = db_q[0];
  assign a1        = da_q[1];
  assign b1        = db_q[1];
  assign a2        = da_q[2];
  assign b2        = db_q[2];
  assign c0        = c_q[0];
  assign c1        = c_q[1];
  assign c2        = c_q[2];
  assign area      = area_q;

endmodule

// File: tb/tb_tri_setup.sv
// -----------------------------------------------------------------------------
// tb_tri_setup
// Self-checking bench for tri_setup. Expected coefficient sets come from an
// integer model and are queued when a triangle is offered; a negedge monitor
// pops and compares them when the DUT emits or culls. Scenario tasks add their
// own timing/handshake checks. Honours TRI_SETUP_CULL_EN the same way the DUT does.
// -----------------------------------------------------------------------------
module tb_tri_setup;
  import tri_setup_pkg::*;

  localparam int W  = TRI_WIDTH;
  localparam int CW = TRI_C_WIDTH;
  localparam int AW = TRI_AREA_WIDTH;
`ifdef TRI_SETUP_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, cull_drop;
  logic signed [W-1:0]  x0, y0, x1, y1, x2, y2;
  logic signed [W-1:0]  a0, b0, a1, b1, a2, b2;
  logic signed [CW-1:0] c0, c1, c2;
  logic signed [AW-1:0] area;

  tri_setup #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .c0(c0), .c1(c1), .c2(c2), .area(area), .cull_drop(cull_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  a0, b0, a1, b1, a2, b2;
    logic [CW-1:0] c0, c1, c2;
    logic [AW-1:0] area;
    logic          cull;
  } exp_t;

  exp_t expq[$];
  int   accq[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, n_acc = 0, n_out = 0, n_cull = 0;
  int   last_acc = -1, prev_acc = -1, rise_cyc = -1, hs_cyc = -1;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // sign-preserving delta with the second-highest bit of the 14-bit difference dropped
  function automatic logic [W-1:0] dlt(input int p, input int q);
    int d, lo;
    d  = p - q;
    lo = d & 32'hFFF;
    return W'((d < 0) ? lo - 4096 : lo);
  endfunction

  function automatic longint wrap_c(input longint v);
    longint r;
    r = v & 64'h3FFFFFF;
    if (r >= 33554432) r = r - 67108864;
    return r;
  endfunction

  function automatic exp_t model(input int ax0, input int ay0, input int ax1,
                                 input int ay1, input int ax2, input int ay2);
    int xs[3], ys[3];
    longint cv[3];
    longint ar;
    int i, j;
    exp_t e;
    xs = '{ax0, ax1, ax2};
    ys = '{ay0, ay1, ay2};
    ar = 0;
    for (int k = 0; k < 3; k++) begin
      i = k;
      j = (k == 2) ? 0 : k + 1;
      cv[k] = wrap_c(longint'(xs[i]) * longint'(ys[j]) - longint'(xs[j]) * longint'(ys[i]));
      ar = ar + cv[k];
    end
    e.a0 = dlt(ys[0], ys[1]); e.b0 = dlt(xs[1], xs[0]);
    e.a1 = dlt(ys[1], ys[2]); e.b1 = dlt(xs[2], xs[1]);
    e.a2 = dlt(ys[2], ys[0]); e.b2 = dlt(xs[0], xs[2]);
    e.c0 = CW'(cv[0]); e.c1 = CW'(cv[1]); e.c2 = CW'(cv[2]);
    e.area = AW'(ar);
    e.cull = CULL && (ar <= 0);
    return e;
  endfunction

  // Scoreboard monitor
  exp_t m_e, m_o;
  int   m_a;
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        accq.push_back(cyc);
        prev_acc = last_acc;
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid && !ov_prev) rise_cyc = cyc;
      if ((out_valid && out_ready) || cull_drop) begin
        checks++;
        if (expq.size() == 0 || accq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d out_valid=%b cull_drop=%b expected none", cyc, out_valid, cull_drop);
        end else begin
          m_e = expq.pop_front();
          m_a = accq.pop_front();
          if (cull_drop) begin
            n_cull++;
            if (!m_e.cull || out_valid || !in_ready || (cyc - m_a) != 5) begin
              errors++;
              $display("FAIL cull_event got cull=1 lat=%0d out_valid=%b in_ready=%b need cull=%b lat=5 out_valid=0 in_ready=1",
                       cyc - m_a, out_valid, in_ready, m_e.cull);
            end
          end else begin
            n_out++;
            hs_cyc = cyc;
            m_o.a0 = a0; m_o.b0 = b0; m_o.a1 = a1; m_o.b1 = b1; m_o.a2 = a2; m_o.b2 = b2;
            m_o.c0 = c0; m_o.c1 = c1; m_o.c2 = c2; m_o.area = area; m_o.cull = 1'b0;
            checks++;
            if (m_o !== m_e) begin
              errors++;
              $display("FAIL out_data got %h need %h", m_o, m_e);
            end
            if ((rise_cyc - m_a) != 5) begin
              errors++;
              $display("FAIL out_latency got %0d need 5", rise_cyc - m_a);
            end
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int ax0, input int ay0, input int ax1,
                         input int ay1, input int ax2, input int ay2);
    x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1);
    y1 = W'(ay1); x2 = W'(ax2); y2 = W'(ay2);
  endtask

  // Offer a triangle and wait for its acceptance; leaves in_valid high.
  task automatic send(input int ax0, input int ay0, input int ax1,
                      input int ay1, input int ax2, input int ay2);
    int acc0;
    set_tri(ax0, ay0, ax1, ay1, ax2, ay2);
    expq.push_back(model(ax0, ay0, ax1, ay1, ax2, ay2));
    in_valid = 1'b1;
    acc0 = n_acc;
    for (int i = 0; i < 50 && n_acc == acc0; i++) step();
    checks++;
    if (n_acc == acc0) begin
      errors++;
      $display("FAIL accept_timeout got no accept need accept within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expq.size() != 0; i++) step();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending need 0", expq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cull_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready=%b out_valid=%b cull=%b need 1 0 0", in_ready, out_valid, cull_drop);
    end
    checks++;
    if ({a0, b0, a1, b1, a2, b2, c0, c1, c2, area} !== '0) begin
      errors++;
      $display("FAIL reset_data got a0=%0d c0=%0d area=%0d need all 0", a0, c0, area);
    end
    step();
  endtask

  task automatic test_ccw();
    int found;
    int got[10], want[10];
    out_ready = 1'b1;
    send(0, 0, 10, 0, 0, 10);
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL ccw_valid got no out_valid need out_valid");
    end
    got  = '{a0, a1, a2, b0, b1, b2, c0, c1, c2, area};
    want = '{0, -10, 10, 10, -10, 0, 0, 100, 0, 100};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL ccw_field%0d got %0d need %0d", i, got[i], want[i]);
      end
    end
    step();
    drain();
  endtask

  task automatic test_cw();
    int o0, c0n;
    o0 = n_out; c0n = n_cull;
    send(0, 0, 0, 10, 10, 0);
    in_valid = 1'b0;
`ifdef TRI_SETUP_CULL_EN
    drain();
    checks++;
    if (n_cull != c0n + 1 || n_out != o0) begin
      errors++;
      $display("FAIL cw_cull got culls=%0d outs=%0d need culls=%0d outs=%0d", n_cull - c0n, n_out - o0, 1, 0);
    end
`else
    begin
      int found;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (out_valid) found = 1;
      end
      checks++;
      if (found == 0 || int'(area) != -100) begin
        errors++;
        $display("FAIL cw_area got valid=%0d area=%0d need valid=1 area=-100", found, area);
      end
      step();
      drain();
      checks++;
      if (n_out != o0 + 1 || n_cull != c0n) begin
        errors++;
        $display("FAIL cw_emit got outs=%0d culls=%0d need 1 0", n_out - o0, n_cull - c0n);
      end
    end
`endif
  endtask

  task automatic test_wrap();
    send(-4096, 0, 4095, 0, 0, 0);
    in_valid = 1'b0;
`ifndef TRI_SETUP_CULL_EN
    begin
      int found;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
        @(negedge clk);
        if (out_valid) found = 1;
      end
      checks++;
      if (found == 0 || int'(b0) != 4095) begin
        errors++;
        $display("FAIL wrap_b0 got valid=%0d b0=%0d need valid=1 b0=4095", found, b0);
      end
      step();
    end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    int found, acc0, out0;
    logic [6*W+3*CW+AW-1:0] snap;
    out_ready = 1'b0;
    send(3, -7, 20, 5, -2, 14);
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL bp_valid got no out_valid need out_valid");
    end
    snap = {a0, b0, a1, b1, a2, b2, c0, c1, c2, area};
    acc0 = n_acc; out0 = n_out;
    set_tri(-50, 7, 11, -300, 99, 1000);
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {a0, b0, a1, b1, a2, b2, c0, c1, c2, area} !== snap) begin
        errors++;
        $display("FAIL bp_hold got out_valid=%b in_ready=%b a0=%0d area=%0d need 1 0 held", out_valid, in_ready, a0, area);
      end
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (n_out != out0 + 1 || (hs_cyc - rise_cyc) != 4 || n_acc != acc0) begin
      errors++;
      $display("FAIL bp_handshake got outs=%0d delay=%0d accepts=%0d need 1 4 0", n_out - out0, hs_cyc - rise_cyc, n_acc - acc0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int o0;
    out_ready = 1'b1;
    send(5, 5, 30, 5, 5, 40);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expq.delete();
    accq.delete();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cull_drop !== 1'b0 ||
        {a0, b0, a1, b1, a2, b2, c0, c1, c2, area} !== '0) begin
      errors++;
      $display("FAIL midreset_state got in_ready=%b out_valid=%b a0=%0d c0=%0d need 1 0 zeros", in_ready, out_valid, a0, c0);
    end
    step();
    o0 = n_out;
    send(-20, -20, 40, -10, 0, 30);
    in_valid = 1'b0;
    drain();
    repeat (8) step();
    checks++;
    if (n_out != o0 + 1) begin
      errors++;
      $display("FAIL midreset_after got outs=%0d need 1", n_out - o0);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    out_ready = 1'b1;
    o0 = n_out;
    send(1, 1, 50, 2, 3, 60);
    send(-4000, -4000, 4000, -3990, 0, 4000);
    in_valid = 1'b0;
    checks++;
    if ((last_acc - prev_acc) != 6) begin
      errors++;
      $display("FAIL b2b_spacing got %0d need 6", last_acc - prev_acc);
    end
    drain();
    checks++;
    if (n_out != o0 + 2) begin
      errors++;
      $display("FAIL b2b_count got %0d need 2", n_out - o0);
    end
  endtask

  initial begin
    test_reset();
    test_ccw();
    test_cw();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish need finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/tri_setup.md
# tri_setup

Triangle setup stage for the raster front end. Accepts one screen-space triangle (three signed vertices) over a valid/ready handshake and computes the three edge-function coefficient sets (A, B, C) plus the doubled signed area. Results go to the rasterizer edge walker. Edge deltas use the pipeline's standard signed delta convention (sign-preserving, one bit dropped), so every delta stays WIDTH bits wide.

## Interface
- WIDTH, 13, vertex coordinate width (signed two's complement).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  triangle offered.
- in_ready  out  1  block can accept a triangle.
- x0, y0, x1, y1, x2, y2  in  WIDTH each  signed vertex coordinates.
- out_valid  out  1  coefficient set available.
- out_ready  in  1  consumer accepts.
- a0, b0, a1, b1, a2, b2  out  WIDTH each  signed edge A/B coefficients.
- c0, c1, c2  out  2*WIDTH each  signed edge C coefficients.
- area  out  2*WIDTH+2  signed doubled area; CCW is positive.
- cull_drop  out  1  one-cycle pulse when a triangle is culled (macro-dependent).

## Operation
- Edge k runs from vertex i to j, where (i,j) = (0,1), (1,2), (2,0).
- A_k = delta(y_i, y_j). B_k = delta(x_j, x_i). C_k = x_i*y_j − x_j*y_i, at full 2*WIDTH precision.
- delta(p, q): form the WIDTH+1-bit signed difference d = p − q. Result = {d[WIDTH], d[WIDTH-2:0]}.
- area = C0 + C1 + C2, sign-extended to 2*WIDTH+2.
- The FSM has four states: IDLE, DELTA, MUL, EMIT.
- IDLE: in_ready = 1. On in_valid & in_ready, latch all six coordinates and go to DELTA.
- DELTA: register all six deltas. Go to MUL with edge counter k = 0.
- MUL: two shared signed multipliers compute x_i*y_j and x_j*y_i for edge k. C_k is registered and added into the area accumulator. k increments each cycle. After k = 2, go to EMIT, or go to IDLE if culled.
- EMIT: out_valid = 1. All outputs are held stable until out_ready = 1. On that handshake, go to IDLE.
- in_ready = 0 in every state except IDLE, so there is no input buffering.
- Reset: every register clears, the state returns to IDLE, and all outputs read 0.
- rst_n low in any state, including mid-MUL or while EMIT is stalled, aborts the triangle with no output.

## Timing
- Accept handshake at edge T. The DELTA state occupies cycle T+1. MUL occupies cycles T+2 to T+4. out_valid rises at T+5.
- With out_ready held at 1, the output handshake occurs at T+5. IDLE is at T+6, and the next triangle can be accepted at T+6.
- Minimum spacing is 6 cycles per triangle.
- out_valid and the data outputs are registered. Nothing from in_* reaches out_* combinationally.
- cull_drop pulses in cycle T+5, in place of out_valid. The state is IDLE at T+5, so in_ready = 1 in that cycle.

## Configuration
- TRI_SETUP_CULL_EN defined: after the last MUL cycle, a triangle with area ≤ 0 (clockwise or degenerate) is discarded. out_valid is not asserted, cull_drop pulses for 1 cycle, and the FSM returns to IDLE.
- TRI_SETUP_CULL_EN undefined: every triangle reaches EMIT regardless of sign, and cull_drop is tied to 0.

## Structure
- Shared package contains:
  - the FSM state enum (IDLE/DELTA/MUL/EMIT);
  - the edge index table (i,j);
  - localparams for the C width (2*WIDTH) and the area width (2*WIDTH+2).
- Sub-module: the existing signed_sub, instantiated six times (x and y for each edge) in the DELTA path. It must match the delta rule above bit-exactly.
- Multipliers and the accumulator stay inline.

## Test plan
- CCW right triangle: (0,0), (10,0), (0,10) → A = (0, −10, 10), B = (10, −10, 0), C = (0, 100, 0), area = 100. out_valid at T+5.
- CW triangle: (0,0), (0,10), (10,0).
  - With the macro: no out_valid, cull_drop pulse at T+5.
  - Without the macro: area = −100 is emitted.
- Delta wrap: x0 = −4096, x1 = 4095, all y = 0 → B0 = 4095, since the dropped bit yields 0_111111111111. With the macro the triangle is also culled (area 0), so check this case with the macro undefined.
- Backpressure: out_ready low for 4 cycles after out_valid rises.
  - Outputs stay constant, in_ready stays 0, and a new in_valid is ignored.
  - The handshake completes on the 5th cycle.
- Reset mid-operation: rst_n low for one cycle during MUL (k = 1).
  - The next cycle shows IDLE, with out_valid = 0 and all outputs = 0.
  - The following triangle produces correct results.
- Back-to-back: in_valid held high with two triangles and out_ready = 1 → acceptances 6 cycles apart, and both coefficient sets are correct and in order.
